// File: rtl/text_renderer.sv
// Text-mode renderer: expands a cell buffer through an 8x8 font into framebuffer pixel writes.
// Optional cursor inversion is built when TEXT_RENDERER_CURSOR_EN is defined.
module text_renderer #(
  parameter int SCALE_LOG2   = 1,
  parameter int PIXEL_WIDTH  = 640,
  parameter int PIXEL_HEIGHT = 480,
  parameter int FONT_CHARS   = 96
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        font_wr,
  input  logic [9:0]  font_addr,
  input  logic [7:0]  font_data,
  input  logic        char_wr,
  input  logic [10:0] char_addr,
  input  logic [15:0] char_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fb_wr,
  output logic [31:0] fb_addr,
  output logic [7:0]  fb_data,
  input  logic        fb_ready,
`ifdef TEXT_RENDERER_CURSOR_EN
  input  logic [10:0] cursor_pos,
`endif
  output logic [2:0]  dbg_state
);

  localparam int CHAR_W     = 8 << SCALE_LOG2;
  localparam int CHAR_H     = CHAR_W;
  localparam int COLS       = PIXEL_WIDTH / CHAR_W;
  localparam int ROWS       = PIXEL_HEIGHT / CHAR_H;
  localparam int CELLS      = COLS * ROWS;
  localparam int CELL_AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int FONT_DEPTH = FONT_CHARS * 8;
  localparam int FONT_AW    = $clog2(FONT_DEPTH);
  localparam int LINE_W     = 3 + SCALE_LOG2;

  localparam logic [LINE_W-1:0] LAST_X    = LINE_W'(CHAR_W - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(CHAR_H - 1);
  // Jump from the last cell of a text row to the first cell of the next one.
  localparam logic [31:0] ROW_STEP = 32'(CHAR_H * PIXEL_WIDTH - (COLS - 1) * CHAR_W);

  // Handshake: a beat transfers on a rising edge where fb_wr & fb_ready; while
  // fb_wr is high and fb_ready low, fb_addr/fb_data hold and fb_wr stays high.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_GLYPH = 3'd2,
    S_EMIT  = 3'd3,
    S_NEXT  = 3'd4
  } state_e;

  state_e             state;
  logic [CELL_AW-1:0] cell_idx;
  logic [15:0]        ccol;
  logic [31:0]        cell_base;
  logic [31:0]        line_base;
  logic [LINE_W-1:0]  line;
  logic [LINE_W-1:0]  x;
  logic [3:0]         fg_q;
  logic [3:0]         bg_q;
  logic [7:0]         code_q;
  logic               code_ok;

  logic [7:0]         font_mem [FONT_DEPTH];
  logic [15:0]        cell_mem [CELLS];
  logic [15:0]        cell_rd;
  logic [7:0]         font_rd;

  logic               accept;
  logic               line_end;
  logic               cell_end;
  logic               glyph_ok;
  logic [7:0]         fa_code;
  logic [2:0]         fa_row;
  logic               font_rd_en;
  logic [FONT_AW-1:0] fa;

  assign dbg_state = state;
  assign accept    = fb_wr & fb_ready;
  assign line_end  = (state == S_EMIT) && accept && (x == LAST_X);
  assign cell_end  = line_end && (line == LAST_LINE);
  assign glyph_ok  = {24'd0, cell_rd[7:0]} < 32'(FONT_CHARS);

  // Font row fetch: first row in GLYPH, next row on the last beat of each line.
  // Out-of-range codes never reach the font RAM.
  always_comb begin
    fa_code    = code_q;
    fa_row     = 3'((line + 1'b1) >> SCALE_LOG2);
    font_rd_en = line_end && !cell_end && code_ok;
    if (state == S_GLYPH) begin
      fa_code    = cell_rd[7:0];
      fa_row     = 3'd0;
      font_rd_en = glyph_ok;
    end
    fa = FONT_AW'({fa_code, fa_row});
  end

  always_ff @(posedge pclk) begin
    if (font_wr && ({22'd0, font_addr} < 32'(FONT_DEPTH)))
      font_mem[FONT_AW'(font_addr)] <= font_data;
    if (char_wr && ({21'd0, char_addr} < 32'(CELLS)))
      cell_mem[CELL_AW'(char_addr)] <= char_data;
    cell_rd <= cell_mem[cell_idx];
    if (font_rd_en)
      font_rd <= font_mem[fa];
  end

  function automatic logic [7:0] shade(input logic [7:0] row, input logic [LINE_W-1:0] px,
                                       input logic ok, input logic [3:0] f, input logic [3:0] b);
    logic [2:0] col;
    col = 3'(px >> SCALE_LOG2);
    return (ok && row[3'd7 - col]) ? {f, f} : {b, b};
  endfunction

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_wr     <= 1'b0;
      fb_addr   <= '0;
      fb_data   <= '0;
      cell_idx  <= '0;
      ccol      <= '0;
      cell_base <= '0;
      line_base <= '0;
      line      <= '0;
      x         <= '0;
      fg_q      <= '0;
      bg_q      <= '0;
      code_q    <= '0;
      code_ok   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            cell_idx  <= '0;
            ccol      <= '0;
            cell_base <= '0;
          end
        end
        S_FETCH: state <= S_GLYPH;
        S_GLYPH: begin
`ifdef TEXT_RENDERER_CURSOR_EN
          if ({21'd0, cursor_pos} == 32'(cell_idx)) begin
            fg_q <= cell_rd[11:8];
            bg_q <= cell_rd[15:12];
          end else
`endif
          begin
            fg_q <= cell_rd[15:12];
            bg_q <= cell_rd[11:8];
          end
          code_q    <= cell_rd[7:0];
          code_ok   <= glyph_ok;
          line      <= '0;
          x         <= '0;
          line_base <= cell_base;
          state     <= S_EMIT;
        end
        S_EMIT: begin
          // fb_wr low here means a font row was just fetched: present pixel 0 of the line.
          if (!fb_wr) begin
            fb_wr   <= 1'b1;
            fb_addr <= line_base;
            fb_data <= shade(font_rd, x, code_ok, fg_q, bg_q);
          end else if (fb_ready) begin
            if (x == LAST_X) begin
              fb_wr <= 1'b0;
              x     <= '0;
              if (line == LAST_LINE) begin
                state <= S_NEXT;
              end else begin
                line      <= line + 1'b1;
                line_base <= line_base + 32'(PIXEL_WIDTH);
              end
            end else begin
              x       <= x + 1'b1;
              fb_addr <= fb_addr + 32'd1;
              fb_data <= shade(font_rd, x + 1'b1, code_ok, fg_q, bg_q);
            end
          end
        end
        S_NEXT: begin
          if (32'(cell_idx) == 32'(CELLS - 1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cell_idx <= cell_idx + 1'b1;
            state    <= S_FETCH;
            if (ccol == 16'(COLS - 1)) begin
              ccol      <= '0;
              cell_base <= cell_base + ROW_STEP;
            end else begin
              ccol      <= ccol + 1'b1;
              cell_base <= cell_base + 32'(CHAR_W);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer on a 640x32 frame (two text rows, 80 cells) at scale 2x.
// Build with TEXT_RENDERER_CURSOR_EN to exercise the cursor port.
module tb_text_renderer;

  localparam int SL    = 1;
  localparam int PW    = 640;
  localparam int PH    = 32;
  localparam int FC    = 96;
  localparam int CW    = 8 << SL;
  localparam int COLS  = PW / CW;
  localparam int CELLS = COLS * (PH / CW);
  localparam int BEATS = CELLS * CW * CW;
  localparam int BOUND = 40000;

  logic        pclk;
  logic        rst_n;
  logic        font_wr;
  logic [9:0]  font_addr;
  logic [7:0]  font_data;
  logic        char_wr;
  logic [10:0] char_addr;
  logic [15:0] char_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        fb_wr;
  logic [31:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_ready;
  logic [10:0] cursor_pos;
  logic [2:0]  dbg_state;

  text_renderer #(
    .SCALE_LOG2(SL), .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .FONT_CHARS(FC)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .font_wr(font_wr), .font_addr(font_addr), .font_data(font_data),
    .char_wr(char_wr), .char_addr(char_addr), .char_data(char_data),
    .start(start), .busy(busy), .done(done),
    .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready),
`ifdef TEXT_RENDERER_CURSOR_EN
    .cursor_pos(cursor_pos),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model of memories and expected beats
  logic [7:0]  font_m [768];
  logic [15:0] cell_m [CELLS];
  logic [7:0]  fb_img [BEATS];
  logic [39:0] exp_q [$];
  int          cursor_m = 0;

  function automatic logic [7:0] model_pix(input int idx, input int ln, input int px);
    logic [15:0] e;
    logic [3:0]  f;
    logic [3:0]  b;
    logic [3:0]  t;
    logic [7:0]  row;
    int          c;
    bit          on;
    e = cell_m[idx];
    f = e[15:12];
    b = e[11:8];
    c = int'(e[7:0]);
`ifdef TEXT_RENDERER_CURSOR_EN
    if (idx == cursor_m) begin
      t = f; f = b; b = t;
    end
`endif
    on = 1'b0;
    if (c < FC) begin
      row = font_m[c * 8 + ln / (1 << SL)];
      on = row[7 - px / (1 << SL)];
    end
    return on ? {f, f} : {b, b};
  endfunction

  task automatic build_expected();
    int a;
    exp_q.delete();
    for (int i = 0; i < CELLS; i++)
      for (int ln = 0; ln < CW; ln++)
        for (int px = 0; px < CW; px++) begin
          a = ((i / COLS) * CW + ln) * PW + (i % COLS) * CW + px;
          exp_q.push_back({32'(a), model_pix(i, ln, px)});
        end
  endtask

  // fb_ready driver
  bit rdy_rand = 1'b0;
  always @(posedge pclk) begin
    #1;
    fb_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // scoreboard monitor, sampled on the falling edge
  bit          sb_en = 1'b0;
  bit          stall_p = 1'b0;
  logic [31:0] hold_addr;
  logic [7:0]  hold_data;
  logic [39:0] e_pop;
  int          beat_cnt;
  int          done_cnt;
  int          last_acc_edge;
  logic [31:0] a_c1;
  logic [31:0] a_c40;
  logic [31:0] a_last;

  always @(negedge pclk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("hold_wr", 32'(fb_wr), 1);
        check("hold_addr", fb_addr, hold_addr);
        check("hold_data", 32'(fb_data), 32'(hold_data));
      end
      stall_p   = fb_wr && !fb_ready;
      hold_addr = fb_addr;
      hold_data = fb_data;
      if (sb_en && fb_wr && fb_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", fb_addr, 32'hFFFF_FFFF);
        end else begin
          e_pop = exp_q.pop_front();
          check("beat_addr", fb_addr, e_pop[39:8]);
          check("beat_data", 32'(fb_data), 32'(e_pop[7:0]));
        end
        if (fb_addr < BEATS) fb_img[fb_addr] = fb_data;
        if (beat_cnt == CW * CW) a_c1 = fb_addr;
        if (beat_cnt == 40 * CW * CW) a_c40 = fb_addr;
        a_last = fb_addr;
        beat_cnt++;
        last_acc_edge = cyc + 1;
      end
      if (sb_en && done) begin
        done_cnt++;
        check("done_lat", 32'(cyc - last_acc_edge), 1);
        check("done_busy", 32'(busy), 0);
      end
    end
  end

  // driver tasks (entered and left #1 after a rising edge)
  task automatic write_font(input int a, input logic [7:0] d);
    font_wr = 1'b1; font_addr = 10'(a); font_data = d; font_m[a] = d;
    @(posedge pclk); #1 font_wr = 1'b0;
  endtask

  task automatic write_cell(input int a, input logic [15:0] d);
    char_wr = 1'b1; char_addr = 11'(a); char_data = d; cell_m[a] = d;
    @(posedge pclk); #1 char_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge pclk); #1 start = 1'b0;
  endtask

  task automatic do_render(input bit first, input bit poke);
    build_expected();
    for (int i = 0; i < BEATS; i++) fb_img[i] = 8'h11;
    beat_cnt = 0; done_cnt = 0; last_acc_edge = 0;
    sb_en = 1'b1;
    pulse_start();
    check("busy_rise", 32'(busy), 1);
    if (first) begin
      check("lat_n0", 32'(fb_wr), 0);
      @(posedge pclk); #1 check("lat_n1", 32'(fb_wr), 0);
      @(posedge pclk); #1 check("lat_n2", 32'(fb_wr), 0);
      @(posedge pclk); #1 check("lat_n3", 32'(fb_wr), 1);
    end
    if (poke) begin
      repeat (100) @(posedge pclk);
      #1 pulse_start();
    end
    for (int i = 0; i < BOUND && done_cnt == 0; i++) @(posedge pclk);
    repeat (4) @(posedge pclk);
    #1;
    check("done_cnt", 32'(done_cnt), 1);
    check("beats_left", 32'(exp_q.size()), 0);
    check("beat_total", 32'(beat_cnt), BEATS);
    check("idle_busy", 32'(busy), 0);
    sb_en = 1'b0;
  endtask

  logic [7:0] c_on;
  logic [7:0] c_off;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    font_wr = 1'b0; font_addr = '0; font_data = '0;
    char_wr = 1'b0; char_addr = '0; char_data = '0;
    cursor_pos = '0;
    for (int i = 0; i < 768; i++) font_m[i] = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_fb_wr", 32'(fb_wr), 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", 32'(fb_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    @(posedge pclk); #1;

    for (int i = 0; i < 16; i++) write_font(i, (i == 8) ? 8'h80 : 8'h00);
    write_cell(0, 16'hF001);
    for (int i = 1; i < CELLS; i++) write_cell(i, 16'h0000);

    // render 1: basic glyph, scaling, addressing, latency
    cursor_m = 0; cursor_pos = 11'd0;
`ifdef TEXT_RENDERER_CURSOR_EN
    c_on = 8'h00; c_off = 8'hFF;
`else
    c_on = 8'hFF; c_off = 8'h00;
`endif
    do_render(1'b1, 1'b0);
    check("img_0", 32'(fb_img[0]), 32'(c_on));
    check("img_1", 32'(fb_img[1]), 32'(c_on));
    check("img_2", 32'(fb_img[2]), 32'(c_off));
    check("img_15", 32'(fb_img[15]), 32'(c_off));
    check("img_640", 32'(fb_img[640]), 32'(c_on));
    check("img_641", 32'(fb_img[641]), 32'(c_on));
    check("img_1280", 32'(fb_img[1280]), 32'(c_off));
    check("cell1_addr", a_c1, 16);
    check("cell40_addr", a_c40, 10240);
    check("last_addr", a_last, BEATS - 1);

    // render 2: invalid code, back-pressure, start ignored while busy, cursor off-screen
    write_cell(0, 16'h5A64);
    cursor_m = CELLS; cursor_pos = 11'(CELLS);
    rdy_rand = 1'b1;
    do_render(1'b0, 1'b1);
    rdy_rand = 1'b0;
    check("inv_0", 32'(fb_img[0]), 32'hAA);
    check("inv_15", 32'(fb_img[15]), 32'hAA);
    check("inv_9615", 32'(fb_img[9615]), 32'hAA);
    check("cell1_bg", 32'(fb_img[16]), 32'h00);

    // render 3: reset mid-frame, then restart
    @(posedge pclk); #1 pulse_start();
    repeat (500) @(posedge pclk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr", 32'(fb_wr), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_addr", fb_addr, 0);
    check("mid_rst_data", 32'(fb_data), 0);
    @(posedge pclk); #1 rst_n = 1'b1;
    repeat (5) @(posedge pclk);
    #1;
    check("post_rst_wr", 32'(fb_wr), 0);
    check("post_rst_busy", 32'(busy), 0);
    pulse_start();
    for (int i = 0; i < 20 && !fb_wr; i++) begin
      @(posedge pclk); #1;
    end
    check("restart_wr", 32'(fb_wr), 1);
    check("restart_addr", fb_addr, 0);
    check("restart_data", 32'(fb_data), 32'(model_pix(0, 0, 0)));
    rst_n = 1'b0;
    repeat (2) @(posedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
